// File: rtl/fabric_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_bus_arbiter_if
//  Description : Request/grant bundle between the fabric bus arbiter and the
//                requesting units (REQ, BUSY line, EN, one-hot grant, status).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fabric_bus_arbiter_if #(
  parameter int UNITS = 4
);
  logic             ARB_ENABLE;        // 1 = new grants allowed
  logic [UNITS-1:0] REQ;               // level request, bit i = unit i
  logic             BUSY_line_MASTER;  // pulled-up line; low = owner driving bus
  logic             EN;                // bus enable, high while a grant is active
  logic [UNITS-1:0] REQUEST_OK;        // one-hot registered grant
  logic [3:0]       GRANT_NUM;         // index of granted unit
  logic             ARB_BUSY;          // arbiter not idle
  logic             TIMEOUT_ERR;       // one-cycle pulse on watchdog abort
  logic [3:0]       ERR_NUM;           // unit index of last aborted grant

  // Arbiter side
  modport master (
    input  ARB_ENABLE, REQ, BUSY_line_MASTER,
    output EN, REQUEST_OK, GRANT_NUM, ARB_BUSY, TIMEOUT_ERR, ERR_NUM
  );

  // Requesting-unit side
  modport slave (
    output ARB_ENABLE, REQ, BUSY_line_MASTER,
    input  EN, REQUEST_OK, GRANT_NUM, ARB_BUSY, TIMEOUT_ERR, ERR_NUM
  );
endinterface
`default_nettype wire

// File: rtl/fabric_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_bus_arbiter
//  Description : Round-robin arbiter for the shared fabric data bus. Grants one
//                unit at a time, tracks ownership through BUSY_line_MASTER and
//                reclaims the bus from a stalled owner with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_bus_arbiter #(
  parameter int UNITS    = 4,
  parameter int START_TO = 16,
  parameter int HOLD_TO  = 255,
  parameter int CNT_W    = 8
) (
  input  logic                 CLK_B,
  input  logic                 RESET,   // asynchronous, active-low
  fabric_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GRANT      = 3'd1,
    S_WAIT_START = 3'd2,
    S_OWN        = 3'd3,
    S_RELEASE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TO);
  localparam logic [CNT_W-1:0] WDOG_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_RST  = 4'(UNITS - 1);

  state_t           state, next_state;
  logic [3:0]       grant_idx, next_idx;
  logic [3:0]       last_ptr, next_last;
  logic [CNT_W-1:0] wdog, next_wdog, wdog_inc;
  logic             en_q, next_en;
  logic [UNITS-1:0] req_ok_q, next_ok;
  logic [3:0]       gnum_q, next_gnum;
  logic             timeout_q, next_timeout;
  logic [3:0]       err_num_q, next_err;
  logic             abort;

  logic [15:0]      req_ext;
  logic [4:0]       cand;
  logic             pick_valid;
  logic [3:0]       pick_idx;

  // Non-existent request bits above UNITS read as zero.
  assign req_ext  = 16'(bus.REQ);
  // Watchdog saturates instead of wrapping.
  assign wdog_inc = (wdog == WDOG_MAX) ? wdog : wdog + CNT_W'(1);

  // Round-robin pick: first set request scanning upward from last+1 with wrap,
  // so the unit just served is looked at last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 4'd0;
    cand       = 5'd0;
    for (int k = 1; k <= UNITS; k++) begin
      cand = {1'b0, last_ptr} + 5'(k);
      if (cand >= 5'(UNITS)) begin
        cand = cand - 5'(UNITS);
      end
      if (!pick_valid && req_ext[cand[3:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
  end

  // Next-state and next-output decode; a watchdog abort overrides the state step.
  always_comb begin
    next_state   = state;
    next_idx     = grant_idx;
    next_last    = last_ptr;
    next_wdog    = wdog;
    next_en      = en_q;
    next_ok      = req_ok_q;
    next_gnum    = gnum_q;
    next_timeout = 1'b0;
    next_err     = err_num_q;
    abort        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.ARB_ENABLE && pick_valid) begin
          next_idx   = pick_idx;
          next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        next_en    = 1'b1;
        next_ok    = UNITS'(1) << grant_idx;
        next_gnum  = grant_idx;
        next_wdog  = '0;
        next_state = S_WAIT_START;
      end
      S_WAIT_START: begin
        // The requester may drop REQ once granted; only the BUSY line matters here.
        if (!bus.BUSY_line_MASTER) begin
          next_state = S_OWN;
          next_wdog  = '0;
        end else if (wdog == START_LIM) begin
          abort = 1'b1;
        end else begin
          next_wdog = wdog_inc;
        end
      end
      S_OWN: begin
        if (bus.BUSY_line_MASTER) begin
          next_en    = 1'b0;
          next_ok    = '0;
          next_state = S_RELEASE;
        end else if (wdog == HOLD_LIM) begin
          abort = 1'b1;
        end else begin
          next_wdog = wdog_inc;
        end
      end
      S_RELEASE: begin
        // Grant is already off; this cycle guarantees an idle bus gap.
        next_last  = grant_idx;
        next_state = S_IDLE;
      end
      default: begin
        next_en    = 1'b0;
        next_ok    = '0;
        next_state = S_IDLE;
      end
    endcase
    if (abort) begin
      next_timeout = 1'b1;
      next_err     = grant_idx;
      next_en      = 1'b0;
      next_ok      = '0;
      next_state   = S_RELEASE;
    end
  end

  // State and registered outputs; reset drops the grant without a clock edge.
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      grant_idx <= 4'd0;
      last_ptr  <= LAST_RST;
      wdog      <= '0;
      en_q      <= 1'b0;
      req_ok_q  <= '0;
      gnum_q    <= 4'd0;
      timeout_q <= 1'b0;
      err_num_q <= 4'd0;
    end else begin
      state     <= next_state;
      grant_idx <= next_idx;
      last_ptr  <= next_last;
      wdog      <= next_wdog;
      en_q      <= next_en;
      req_ok_q  <= next_ok;
      gnum_q    <= next_gnum;
      timeout_q <= next_timeout;
      err_num_q <= next_err;
    end
  end

  assign bus.EN          = en_q;
  assign bus.REQUEST_OK  = req_ok_q;
  assign bus.GRANT_NUM   = gnum_q;
  assign bus.ARB_BUSY    = (state != S_IDLE);
  assign bus.TIMEOUT_ERR = timeout_q;
  assign bus.ERR_NUM     = err_num_q;

endmodule
`default_nettype wire

// File: tb/tb_fabric_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fabric_bus_arbiter
//  Description : Self-checking bench for fabric_bus_arbiter: vector table,
//                hand sequences for reset/enable corners, and random owner
//                behaviour checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_bus_arbiter;

  localparam int UNITS    = 4;
  localparam int START_TO = 16;
  localparam int HOLD_TO  = 255;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   m_last;     // model: unit served last
  int   exp_err;    // model: expected ERR_NUM

  fabric_bus_arbiter_if #(.UNITS(UNITS)) bus ();

  fabric_bus_arbiter #(
    .UNITS(UNITS), .START_TO(START_TO), .HOLD_TO(HOLD_TO), .CNT_W(8)
  ) dut (
    .CLK_B(clk),
    .RESET(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         d;    // cycles owner waits after EN before pulling BUSY low
    int         h;    // cycles BUSY is held low
    int         g;    // expected granted unit
    int         len;  // expected EN-high cycles after the grant shows
    bit         to;   // expected watchdog abort
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One full grant: request from idle, owner behaviour (d,h), release back to idle.
  task automatic do_txn(input logic [3:0] req, input int d, input int h, input int eg,
                        input int elen, input bit eto, input bit toggle_en);
    int t;
    bit done;
    bus.ARB_ENABLE       = 1'b1;
    bus.REQ              = req;
    bus.BUSY_line_MASTER = 1'b1;
    @(posedge clk); #1;
    chk("en_after_1_edge", bus.EN, 0);
    @(posedge clk); #1;
    chk("en_after_2_edges", bus.EN, 1);
    chk("grant_num", bus.GRANT_NUM, eg);
    chk("request_ok", bus.REQUEST_OK, 32'd1 << eg);
    chk("arb_busy_granted", bus.ARB_BUSY, 1);
    bus.REQ = '0;
    t = 0;
    done = 1'b0;
    while (!done) begin
      t++;
      bus.BUSY_line_MASTER = !(t >= d + 1 && t <= d + h);
      if (toggle_en) bus.ARB_ENABLE = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!bus.EN || t >= 400) done = 1'b1;
    end
    chk("grant_len", t, elen);
    chk("timeout_err", bus.TIMEOUT_ERR, eto);
    if (eto) exp_err = eg;
    chk("err_num", bus.ERR_NUM, exp_err);
    chk("request_ok_clr", bus.REQUEST_OK, 0);
    m_last = eg;
    bus.BUSY_line_MASTER = 1'b1;
    bus.ARB_ENABLE       = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", bus.ARB_BUSY, 0);
    chk("timeout_pulse_end", bus.TIMEOUT_ERR, 0);
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0]  = '{4'b1111, 1,   3, 0,   5, 1'b0};
    tbl[1]  = '{4'b1111, 2,   3, 1,   6, 1'b0};
    tbl[2]  = '{4'b1111, 0,   3, 2,   4, 1'b0};
    tbl[3]  = '{4'b1111, 0,   3, 3,   4, 1'b0};
    tbl[4]  = '{4'b1111, 0,   3, 0,   4, 1'b0};
    tbl[5]  = '{4'b0100, 0,   5, 2,   6, 1'b0};
    tbl[6]  = '{4'b0010, 17,  1, 1,  17, 1'b1};  // start watchdog
    tbl[7]  = '{4'b1000, 0, 300, 3, 257, 1'b1};  // hold watchdog
    tbl[8]  = '{4'b0001, 16,  1, 0,  18, 1'b0};  // latest legal start
    tbl[9]  = '{4'b0011, 0, 256, 1, 257, 1'b0};  // longest legal hold
    tbl[10] = '{4'b0011, 0, 257, 0, 257, 1'b1};  // one cycle too long

    rst_n                = 1'b0;
    bus.ARB_ENABLE       = 1'b0;
    bus.REQ              = '0;
    bus.BUSY_line_MASTER = 1'b1;
    m_last  = UNITS - 1;
    exp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", bus.EN, 0);
    chk("rst_request_ok", bus.REQUEST_OK, 0);
    chk("rst_grant_num", bus.GRANT_NUM, 0);
    chk("rst_arb_busy", bus.ARB_BUSY, 0);
    chk("rst_timeout", bus.TIMEOUT_ERR, 0);
    chk("rst_err_num", bus.ERR_NUM, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_txn(tbl[i].req, tbl[i].d, tbl[i].h, tbl[i].g, tbl[i].len, tbl[i].to, 1'b0);
    end

    // Reset while the owner holds the bus: everything drops without a clock edge.
    bus.ARB_ENABLE = 1'b1;
    bus.REQ        = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_grant", bus.GRANT_NUM, 2);
    bus.REQ = '0;
    bus.BUSY_line_MASTER = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_en", bus.EN, 0);
    chk("async_rst_request_ok", bus.REQUEST_OK, 0);
    chk("async_rst_arb_busy", bus.ARB_BUSY, 0);
    bus.BUSY_line_MASTER = 1'b1;
    m_last  = UNITS - 1;
    exp_err = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable dropped during ownership: owner completes, next grant waits.
    bus.REQ = 4'b0011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_reset_first_grant", bus.GRANT_NUM, 0);
    chk("post_reset_en", bus.EN, 1);
    bus.REQ = 4'b0010;
    bus.BUSY_line_MASTER = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.ARB_ENABLE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("en_held_while_disabled", bus.EN, 1);
    bus.BUSY_line_MASTER = 1'b1;
    @(posedge clk); #1;
    chk("owner_completes", bus.EN, 0);
    chk("no_abort_on_disable", bus.TIMEOUT_ERR, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_grant_while_disabled", bus.EN, 0);
    chk("idle_while_disabled", bus.ARB_BUSY, 0);
    bus.ARB_ENABLE = 1'b1;
    @(posedge clk); #1;
    chk("reenable_1_edge", bus.EN, 0);
    @(posedge clk); #1;
    chk("reenable_2_edges", bus.EN, 1);
    chk("reenable_grant", bus.GRANT_NUM, 1);
    bus.REQ = '0;
    bus.BUSY_line_MASTER = 1'b0;
    @(posedge clk); #1;
    bus.BUSY_line_MASTER = 1'b1;
    @(posedge clk); #1;
    chk("reenable_release", bus.EN, 0);
    @(posedge clk); #1;
    m_last = 1;

    // Random requests and owner behaviour against the transaction model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] req;
      int d, h, g, len;
      bit to;
      req = 4'($urandom_range(1, 15));
      d   = $urandom_range(0, 20);
      h   = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 30);
      g   = -1;
      for (int k = 1; k <= UNITS; k++) begin
        int c;
        c = (m_last + k) % UNITS;
        if (g < 0 && req[c]) g = c;
      end
      if (d > START_TO) begin
        len = START_TO + 1;
        to  = 1'b1;
      end else if (h > HOLD_TO + 1) begin
        len = d + HOLD_TO + 2;
        to  = 1'b1;
      end else begin
        len = d + h + 1;
        to  = 1'b0;
      end
      do_txn(req, d, h, g, len, to, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
